// File: rtl/tx_bram_playback_controller.sv
// Transmit playback buffer: samples are loaded into a simple dual-port RAM while
// idle, then clocked out one per DAC tick after start_tx until the loaded count is used up.
module tx_bram_playback_controller #(
  parameter int MEMORY_LENGTH = 510,
  parameter int ADDR_WIDTH    = 9
) (
  input  logic                      ctx_clk,
  input  logic                      rtx_rst,
  input  logic                      etx_en,
  input  logic                      wr_en_RAM,
  input  logic signed [15:0]        data_in_RAM,
  input  logic                      clear_buf,
  input  logic                      start_tx,
  input  logic                      abort_tx,
  input  logic                      new_sample_trig,
  output logic signed [15:0]        data_out_tx,
  output logic                      data_valid_tx,
  output logic                      busy_tx,
  output logic                      done_tx,
  output logic [ADDR_WIDTH:0]       load_count,
  output logic                      full_tx
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LEN = (ADDR_WIDTH+1)'(MEMORY_LENGTH);

  logic signed [15:0]  mem [MEMORY_LENGTH];
  state_t              state_q;
  logic [ADDR_WIDTH:0] rd_ptr_q, load_cnt_q, load_cnt_d;
  logic signed [15:0]  dout_q;
  logic                vld_q, done_q;
  logic                full, wr_ok, start_ok, issue, last;

  always_comb begin
    full     = (load_cnt_q == MEM_LEN);
    wr_ok    = etx_en && (state_q == IDLE) && wr_en_RAM && !clear_buf && !full;
    start_ok = etx_en && (state_q == IDLE) && start_tx && (load_cnt_q != '0);
    // abort takes priority over a coincident tick, so no read is issued
    issue    = etx_en && (state_q == PLAY) && new_sample_trig && !abort_tx;
    last     = ((rd_ptr_q + 1'b1) == load_cnt_q);
    load_cnt_d = load_cnt_q;
    if (state_q == IDLE) begin
      if (clear_buf)  load_cnt_d = '0;
      else if (wr_ok) load_cnt_d = load_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ctx_clk) begin
    if (wr_ok) mem[load_cnt_q[ADDR_WIDTH-1:0]] <= data_in_RAM;
  end

  // The RAM read register doubles as the output holding register, so the sample
  // lands one cycle after its tick and persists until the next read.
  always_ff @(posedge ctx_clk or posedge rtx_rst) begin
    if (rtx_rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      load_cnt_q <= '0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
    end else if (etx_en) begin
      vld_q  <= issue;
      done_q <= issue && last;
      if (issue) dout_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      load_cnt_q <= load_cnt_d;
      case (state_q)
        IDLE: if (start_ok) begin
          state_q  <= PLAY;
          rd_ptr_q <= '0;
        end
        PLAY: begin
          if (abort_tx) state_q <= IDLE;
          else if (issue) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            if (last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end
  end

  assign data_out_tx   = dout_q;
  assign data_valid_tx = vld_q;
  assign done_tx       = done_q;
  assign busy_tx       = (state_q == PLAY);
  assign load_count    = load_cnt_q;
  assign full_tx       = full;

endmodule

// File: tb/tb_tx_bram_playback_controller.sv
// Directed bench for the playback controller: load, play, replay, abort, enable
// gating, capacity saturation and asynchronous reset, all with fixed expectations.
module tb_tx_bram_playback_controller;

  logic               ctx_clk = 1'b0;
  logic               rtx_rst, etx_en, wr_en_RAM, clear_buf, start_tx, abort_tx, new_sample_trig;
  logic signed [15:0] data_in_RAM, data_out_tx;
  logic               data_valid_tx, busy_tx, done_tx, full_tx;
  logic [9:0]         load_count;
  int                 total = 0, bad = 0;

  tx_bram_playback_controller #(.MEMORY_LENGTH(510), .ADDR_WIDTH(9)) dut (
    .ctx_clk(ctx_clk), .rtx_rst(rtx_rst), .etx_en(etx_en), .wr_en_RAM(wr_en_RAM),
    .data_in_RAM(data_in_RAM), .clear_buf(clear_buf), .start_tx(start_tx),
    .abort_tx(abort_tx), .new_sample_trig(new_sample_trig), .data_out_tx(data_out_tx),
    .data_valid_tx(data_valid_tx), .busy_tx(busy_tx), .done_tx(done_tx),
    .load_count(load_count), .full_tx(full_tx)
  );

  always #5 ctx_clk = ~ctx_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge ctx_clk); #1;
  endtask

  task automatic load(input logic signed [15:0] v);
    wr_en_RAM = 1'b1; data_in_RAM = v; step; wr_en_RAM = 1'b0;
  endtask

  task automatic start;
    start_tx = 1'b1; step; start_tx = 1'b0;
  endtask

  task automatic tick_chk(input string tag, input logic signed [15:0] v, input logic lst);
    new_sample_trig = 1'b1; step; new_sample_trig = 1'b0;
    chk({tag, "_vld"},  data_valid_tx, 1);
    chk({tag, "_data"}, data_out_tx, v);
    chk({tag, "_done"}, done_tx, lst);
    chk({tag, "_busy"}, busy_tx, !lst);
  endtask

  logic signed [15:0] v3 [3];
  logic signed [15:0] v4 [4];

  initial begin
    v3[0] = 16'sd3; v3[1] = -16'sd5; v3[2] = 16'sd7;
    v4[0] = 16'sd10; v4[1] = -16'sd20; v4[2] = 16'sd30; v4[3] = 16'sd40;
    rtx_rst = 1'b1; etx_en = 1'b1; wr_en_RAM = 0; clear_buf = 0; start_tx = 0;
    abort_tx = 0; new_sample_trig = 0; data_in_RAM = '0;
    #3;
    chk("rst_vld", data_valid_tx, 0); chk("rst_busy", busy_tx, 0);
    chk("rst_done", done_tx, 0); chk("rst_cnt", load_count, 0);
    chk("rst_full", full_tx, 0); chk("rst_data", data_out_tx, 0);
    step; step; rtx_rst = 1'b0;

    // three samples, tick every 4 cycles
    for (int i = 0; i < 3; i++) load(v3[i]);
    chk("l3_cnt", load_count, 3);
    start;
    chk("l3_busy", busy_tx, 1);
    for (int i = 0; i < 3; i++) begin
      step; step; step;
      chk("l3_gap_vld", data_valid_tx, 0);
      tick_chk("l3", v3[i], i == 2);
    end
    step;
    chk("l3_hold", data_out_tx, 16'sd7); chk("l3_after_vld", data_valid_tx, 0);
    chk("l3_after_busy", busy_tx, 0);

    // empty buffer start, clear vs write
    clear_buf = 1'b1; step; clear_buf = 1'b0;
    chk("clr_cnt", load_count, 0);
    start;
    chk("empty_start_busy", busy_tx, 0);
    load(16'sd1);
    chk("one_cnt", load_count, 1);
    clear_buf = 1'b1; wr_en_RAM = 1'b1; data_in_RAM = 16'sd99; step;
    clear_buf = 1'b0; wr_en_RAM = 1'b0;
    chk("clr_wr_cnt", load_count, 0);

    // four samples, back-to-back ticks, replayed twice
    for (int i = 0; i < 4; i++) load(v4[i]);
    for (int rep = 0; rep < 2; rep++) begin
      start_tx = 1'b1; new_sample_trig = 1'b1; step; start_tx = 1'b0; new_sample_trig = 1'b0;
      chk("b2b_start_vld", data_valid_tx, 0); chk("b2b_start_busy", busy_tx, 1);
      wr_en_RAM = 1'b1; clear_buf = 1'b1; data_in_RAM = 16'sd55; step;
      wr_en_RAM = 1'b0; clear_buf = 1'b0;
      chk("play_wr_ignored", load_count, 4);
      for (int i = 0; i < 4; i++) tick_chk("b2b", v4[i], i == 3);
    end

    // abort coincident with second tick
    start;
    tick_chk("abt1", v4[0], 1'b0);
    new_sample_trig = 1'b1; abort_tx = 1'b1; step; new_sample_trig = 1'b0; abort_tx = 1'b0;
    chk("abt_vld", data_valid_tx, 0); chk("abt_done", done_tx, 0); chk("abt_busy", busy_tx, 0);
    step;
    chk("abt_after_vld", data_valid_tx, 0);

    // enable low freezes playback for 10 ticks
    start;
    tick_chk("en1", v4[0], 1'b0);
    etx_en = 1'b0; new_sample_trig = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      chk("en_off_vld", data_valid_tx, 0);
      chk("en_off_busy", busy_tx, 1);
    end
    chk("en_off_hold", data_out_tx, v4[0]);
    new_sample_trig = 1'b0; etx_en = 1'b1;
    tick_chk("en_resume", v4[1], 1'b0);
    abort_tx = 1'b1; step; abort_tx = 1'b0;

    // capacity: 510 samples plus one rejected write
    clear_buf = 1'b1; step; clear_buf = 1'b0;
    for (int i = 0; i < 510; i++) load(16'(i * 3 - 700));
    chk("full_pre", full_tx, 1);
    load(16'h7abc);
    chk("full_cnt", load_count, 510); chk("full_flag", full_tx, 1);
    start;
    for (int i = 0; i < 510; i++) tick_chk("full_play", 16'(i * 3 - 700), i == 509);
    new_sample_trig = 1'b1; step; new_sample_trig = 1'b0;
    chk("full_extra_vld", data_valid_tx, 0);
    chk("full_last_hold", data_out_tx, 16'(509 * 3 - 700));

    // asynchronous reset in the middle of a cycle during PLAY
    start;
    tick_chk("ar1", 16'(-700), 1'b0);
    new_sample_trig = 1'b1;
    #2 rtx_rst = 1'b1;
    #1;
    chk("ar_vld", data_valid_tx, 0); chk("ar_busy", busy_tx, 0);
    chk("ar_done", done_tx, 0); chk("ar_data", data_out_tx, 0);
    chk("ar_cnt", load_count, 0); chk("ar_full", full_tx, 0);
    new_sample_trig = 1'b0;
    step;
    chk("ar_held_done", done_tx, 0);
    rtx_rst = 1'b0;
    step;
    chk("ar_post_busy", busy_tx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_bram_playback_controller.md
TX_BRAM_PLAYBACK_CONTROLLER -- requirements
Module: tx_bram_playback_controller

Interface
REQ-001 SHALL have parameter MEMORY_LENGTH, default 510, sample capacity of the internal buffer (max 512).
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, address width of the internal buffer.
REQ-003 SHALL have port ctx_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rtx_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port etx_en  input  1  block enable; low freezes all state.
REQ-006 SHALL have port wr_en_RAM  input  1  load strobe; writes data_in_RAM into the buffer.
REQ-007 SHALL have port data_in_RAM  input  16 signed  sample to load.
REQ-008 SHALL have port clear_buf  input  1  empties the buffer (load count to 0).
REQ-009 SHALL have port start_tx  input  1  single-cycle playback request.
REQ-010 SHALL have port abort_tx  input  1  single-cycle playback cancel.
REQ-011 SHALL have port new_sample_trig  input  1  DAC sample-rate tick; one sample out per tick.
REQ-012 SHALL have port data_out_tx  output  16 signed  played sample.
REQ-013 SHALL have port data_valid_tx  output  1  one-cycle pulse qualifying data_out_tx.
REQ-014 SHALL have port busy_tx  output  1  high while in PLAY.
REQ-015 SHALL have port done_tx  output  1  one-cycle pulse on last played sample.
REQ-016 SHALL have port load_count  output  ADDR_WIDTH+1  number of samples loaded.
REQ-017 SHALL have port full_tx  output  1  high when load_count == MEMORY_LENGTH.

Function
REQ-018 SHALL contain an inferred simple dual-port RAM, MEMORY_LENGTH x 16, synchronous read, 1-cycle read latency.
REQ-019 SHALL implement two states, IDLE and PLAY; busy_tx = (state == PLAY).
REQ-020 In IDLE, wr_en_RAM SHALL write data_in_RAM at address load_count, then increment load_count.
REQ-021 Writes when full_tx = 1 SHALL be ignored; load_count saturates at MEMORY_LENGTH, no wrap.
REQ-022 In PLAY, wr_en_RAM and clear_buf SHALL be ignored.
REQ-023 In IDLE, clear_buf SHALL set load_count to 0 next cycle; with simultaneous wr_en_RAM, clear wins and nothing is written.
REQ-024 start_tx in IDLE with load_count > 0 SHALL enter PLAY next cycle with read pointer 0; with load_count = 0 it SHALL be ignored; in PLAY it SHALL be ignored.
REQ-025 new_sample_trig coincident with the accepted start_tx SHALL NOT issue a read; the first read SHALL be on the first tick after entry to PLAY.
REQ-026 In PLAY, each new_sample_trig SHALL issue one read at the read pointer and increment it.
REQ-027 data_out_tx SHALL update and data_valid_tx SHALL pulse exactly 1 cycle after the issuing tick; back-to-back ticks SHALL yield back-to-back valid samples.
REQ-028 data_out_tx SHALL hold its last value between pulses and after playback.
REQ-029 Read issued at address load_count-1 SHALL be the last; done_tx SHALL pulse together with its data_valid_tx, and state SHALL return to IDLE in that same cycle.
REQ-030 Ticks after the last read issue and before return to IDLE SHALL be ignored.
REQ-031 load_count and buffer contents SHALL be retained after playback so a new start_tx replays the same waveform.
REQ-032 abort_tx in PLAY SHALL return to IDLE next cycle; any read in flight SHALL be discarded (no data_valid_tx, no done_tx); abort wins over a coincident tick.
REQ-033 With etx_en = 0, state, pointers, load_count and data_out_tx SHALL hold; all inputs ignored; data_valid_tx and done_tx SHALL be 0.

Reset
REQ-034 Asserting rtx_rst SHALL immediately force: state IDLE, read pointer 0, load_count 0, data_out_tx 0, data_valid_tx 0, done_tx 0, busy_tx 0, full_tx 0.
REQ-035 Reset mid-PLAY SHALL abort playback without done_tx; RAM contents are not cleared and are unspecified to the user.

Verification
REQ-036 Load 3, -5, 7 then start_tx, ticks every 4 cycles -> data_valid_tx pulses 1 cycle after each tick with 3, -5, 7; done_tx with 7; busy_tx low after.
REQ-037 Load 510 samples then 1 more write -> full_tx = 1, load_count = 510, extra sample never played.
REQ-038 start_tx with load_count = 0 -> busy_tx stays 0; clear_buf plus wr_en_RAM same cycle -> load_count 0.
REQ-039 Load 4, start, ticks on 4 consecutive cycles -> 4 consecutive valid cycles, done_tx on 4th; replay gives identical sequence.
REQ-040 abort_tx on same cycle as 2nd tick of 4-sample playback -> only 1 valid sample output, no done_tx, IDLE next cycle.
REQ-041 rtx_rst pulse mid-PLAY, asynchronous to ctx_clk -> all outputs 0 before next edge; etx_en = 0 for 10 ticks -> no valid pulses, resumes at same pointer.
